// File: rtl/systolic_feeder.sv
// systolic_feeder: input stage of the systolic array. Loads N weight rows
// into the PE grid, then streams activation vectors through a diagonal skew
// (row r delayed by r cycles), drains the skew and pulses done.
// Optional build macro: SYSTOLIC_FEEDER_ERR_EN enables sticky protocol-error
// detection on err; without it err is tied low.
module systolic_feeder #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           start,
  input  logic           float_in,
  input  logic           w_valid,
  output logic           w_ready,
  input  logic [N*W-1:0] w_data,
  input  logic           a_valid,
  output logic           a_ready,
  input  logic [N*W-1:0] a_data,
  input  logic           a_last,
  output logic [N-1:0]   load_row,
  output logic [N*W-1:0] weight_bus,
  output logic [N*W-1:0] row_value,
  output logic [N-1:0]   row_valid,
  output logic           float_out,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   row_cnt, row_cnt_nx;
  logic [DW-1:0]   drn_cnt, drn_cnt_nx;
  logic            float_q, float_nx;
  logic            w_fire;
  logic            a_fire;

  assign w_fire    = w_valid && (state == LOAD_W);
  assign a_fire    = a_valid && (state == STREAM);
  assign busy      = (state != IDLE);
  assign float_out = float_q;

  // State, row counter, drain counter and latched number format
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      row_cnt <= '0;
      drn_cnt <= '0;
      float_q <= 1'b0;
    end else begin
      state   <= state_nx;
      row_cnt <= row_cnt_nx;
      drn_cnt <= drn_cnt_nx;
      float_q <= float_nx;
    end
  end

  // Next-state and handshake outputs; DRAIN spends N bubble cycles, then a
  // final cycle that pulses done while the skew is already empty
  always_comb begin
    state_nx   = state;
    row_cnt_nx = row_cnt;
    drn_cnt_nx = drn_cnt;
    float_nx   = float_q;
    w_ready    = 1'b0;
    a_ready    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          float_nx   = float_in;
          row_cnt_nx = '0;
          drn_cnt_nx = '0;
          state_nx   = LOAD_W;
        end
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          row_cnt_nx = row_cnt + 1'b1;
          if (row_cnt == CW'(N - 1)) state_nx = STREAM;
        end
      end
      STREAM: begin
        a_ready = 1'b1;
        if (a_valid && a_last) begin
          drn_cnt_nx = '0;
          state_nx   = DRAIN;
        end
      end
      DRAIN: begin
        if (drn_cnt == DW'(N)) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else begin
          drn_cnt_nx = drn_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Weight strobe is combinational from the handshake so the PE row loads
  // in the same cycle the beat is accepted
  always_comb begin
    load_row   = '0;
    weight_bus = '0;
    if (w_fire) begin
      load_row[row_cnt] = 1'b1;
      weight_bus        = w_data;
    end
  end

  // Skew pipeline: lane r holds r+1 stages and never stalls
  for (genvar r = 0; r < N; r++) begin : g_lane
    logic [W-1:0] val_q [r+1];
    logic         vld_q [r+1];

    // Insert the accepted lane value (or a zero bubble) and shift the lane
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        for (int unsigned k = 0; k <= unsigned'(r); k++) begin
          val_q[k] <= '0;
          vld_q[k] <= 1'b0;
        end
      end else begin
        val_q[0] <= a_fire ? a_data[r*W +: W] : '0;
        vld_q[0] <= a_fire;
        for (int unsigned k = 1; k <= unsigned'(r); k++) begin
          val_q[k] <= val_q[k-1];
          vld_q[k] <= vld_q[k-1];
        end
      end
    end

    assign row_value[r*W +: W] = val_q[r];
    assign row_valid[r]        = vld_q[r];
  end

`ifdef SYSTOLIC_FEEDER_ERR_EN
  logic err_q;

  // Sticky protocol error: beats offered in the wrong phase or start while busy
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_q <= 1'b0;
    end else if ((w_valid && (state != LOAD_W)) ||
                 (a_valid && ((state == IDLE) || (state == LOAD_W))) ||
                 (start && busy)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
